// File: rtl/pwm_pin_control_dt.sv
// Complementary PWM pin driver with dead-time insertion, per-pin polarity,
// per-pin enables and a latched fault shutdown. One small FSM per channel
// decides which side may be active; a registered output stage applies the
// enables, the polarity and the stop/fault forcing.
//
// Handshake note: this block has no valid/ready interfaces. Every input is
// sampled on each rising clock edge, and every output is a plain registered
// level.
module pwm_pin_control_dt #(
  parameter int                    N_CHANNELS = 3,
  parameter int                    DT_WIDTH   = 16,
  parameter logic [N_CHANNELS-1:0] INVERT_A   = '0,
  parameter logic [N_CHANNELS-1:0] INVERT_B   = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2*N_CHANNELS-1:0] enable_outputs,
  input  logic                    counter_stopped,
  input  logic [N_CHANNELS-1:0]   match_high,
  input  logic [N_CHANNELS-1:0]   match_low,
  input  logic [DT_WIDTH-1:0]     deadtime,
  input  logic                    fault,
  input  logic                    fault_clear,
  output logic [N_CHANNELS-1:0]   out_a,
  output logic [N_CHANNELS-1:0]   out_b,
  output logic                    fault_latched,
  // Debug view of each channel FSM: channel i occupies bits [2i+1:2i]
  output logic [2*N_CHANNELS-1:0] stateDbg
);

  typedef enum logic [1:0] {
    SAFE = 2'd0,
    DEAD = 2'd1,
    A_ON = 2'd2,
    B_ON = 2'd3
  } chanState_t;

  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  // The current edge forces every channel to SAFE. The registered latch
  // keeps the pins off until a clear arrives; the live fault request acts
  // on the very edge it is seen.
  logic shutdown;
  assign shutdown = counter_stopped | fault | fault_latched;

  // Fault latch: set by any fault, cleared only by a clear that is not
  // accompanied by a fault on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_latched <= 1'b0;
    end else if (fault) begin
      fault_latched <= 1'b1;
    end else if (fault_clear) begin
      fault_latched <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : gChan
    chanState_t          state;
    logic [DT_WIDTH-1:0] cnt;
    logic                target;   // 1 = A side wanted, 0 = B side wanted
    logic                req;
    logic                sideDiffers;
    logic                outA;
    logic                outB;

    assign req = ~match_high[i] & ~match_low[i];

    // SAFE counts as differing from both sides, so leaving SAFE always
    // passes through DEAD when the dead time is non-zero.
    assign sideDiffers = (state == SAFE) |
                         ((state == A_ON) & ~req) |
                         ((state == B_ON) &  req);

    // Channel FSM: side selection with dead-time counting
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state  <= SAFE;
        cnt    <= '0;
        target <= 1'b0;
      end else if (shutdown) begin
        state  <= SAFE;
        cnt    <= '0;
      end else begin
        case (state)
          DEAD: begin
            if (cnt > CNT_ONE) begin
              // A request change mid-window restarts the whole window
              if (req != target) begin
                target <= req;
                cnt    <= deadtime;
              end else begin
                cnt    <= cnt - CNT_ONE;
              end
            end else begin
              state <= target ? A_ON : B_ON;
              cnt   <= '0;
            end
          end
          default: begin
            if (sideDiffers) begin
              target <= req;
              if (deadtime == '0) begin
                state <= req ? A_ON : B_ON;
              end else begin
                state <= DEAD;
                cnt   <= deadtime;
              end
            end
          end
        endcase
      end
    end

    // Output stage: one cycle behind the FSM, but stop/fault act at once
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        outA <= INVERT_A[i];
        outB <= INVERT_B[i];
      end else begin
        outA <= (~shutdown & (state == A_ON) & enable_outputs[2*i])   ^ INVERT_A[i];
        outB <= (~shutdown & (state == B_ON) & enable_outputs[2*i+1]) ^ INVERT_B[i];
      end
    end

    assign out_a[i]          = outA;
    assign out_b[i]          = outB;
    assign stateDbg[2*i +: 2] = state;
  end

endmodule
